exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception/interrupt controller at the MEM/WB boundary of the MIPS pipeline.
- Drives the CP0 register block's exception interface: exception_en, is_exception, is_interrupt, excepttype, pc_next, is_slot.
- Consumes CP0 status/cause/epc, with write-back MTC0 forwarding applied before use.
- Decides whether the MEM-stage instruction traps, sequences the pipeline flush, and hands the redirect PC to fetch with a valid/ready handshake.

Parameters:
- ADDR_W, 32, instruction address width.
- EXC_TYPE_W, 32, exception-type bus width; low 5 bits are ExcCode.
- EXC_VECTOR, 32'h0000_0020, handler entry address.
- FLUSH_CYCLES, 2, cycles flush_o is held, range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_valid_i  in  1  MEM-stage instruction valid
- mem_flags_i  in  6  raw flags {eret, brk, syscall, trap, ov, ri}, bit 5..0
- mem_pc_i  in  ADDR_W  MEM-stage PC
- mem_is_slot_i  in  1  instruction is in a delay slot
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- wb_cp0_we_i  in  1  MTC0 write in WB
- wb_cp0_waddr_i  in  5  MTC0 register address
- wb_cp0_data_i  in  32  MTC0 data
- exception_en_o  out  1  one-cycle commit pulse to CP0
- is_exception_o  out  1  synchronous exception or ERET
- is_interrupt_o  out  1  interrupt taken
- excepttype_o  out  EXC_TYPE_W  encoded type to CP0
- pc_next_o  out  ADDR_W  EPC value to CP0
- is_slot_o  out  1  slot flag to CP0
- flush_o  out  1  pipeline flush
- new_pc_o  out  ADDR_W  redirect target
- new_pc_valid_o  out  1  redirect valid
- new_pc_ready_i  in  1  fetch accepts redirect

Behaviour:
- Forwarding: if wb_cp0_we_i and waddr matches STATUS(12), CAUSE(13) or EPC(14), use wb_cp0_data_i in place of that CP0 input.
  - For CAUSE, forward only bits [9:8]; all other CAUSE bits come from cp0_cause_i.
- Interrupt condition: mem_valid_i & fwd_status[0] & ~fwd_status[1] & |(fwd_cause[15:8] & fwd_status[15:8]).
- Priority, highest first: interrupt > ri > ov > trap > syscall > brk > eret.
- ExcCode (excepttype_o[4:0]): int 0x00, syscall 0x08, brk 0x09, ri 0x0a, ov 0x0c, trap 0x0d, eret 0x0e (`EXCEPTION_ERET). Upper bits are zero.
- Flags are ignored when mem_valid_i=0. Multiple flags: only the highest-priority one is taken.
- EPC value: pc_next_o = mem_is_slot_i ? mem_pc_i-4 : mem_pc_i (modulo 2^ADDR_W, wraps at 0).
- Target: eret → fwd_epc; all others → EXC_VECTOR.
- FSM:
  - IDLE:
    - Evaluates every cycle.
    - On a hit, latches type, pc_next, is_slot and target, then goes to FLUSH.
  - FLUSH:
    - flush_o=1 for exactly FLUSH_CYCLES cycles, counted by a 4-bit down-counter.
    - exception_en_o=1 in the first FLUSH cycle only.
    - is_exception_o / is_interrupt_o and the latched fields are valid in that cycle and held until the return to IDLE.
    - Afterwards goes to REDIRECT.
  - REDIRECT:
    - new_pc_valid_o=1 with new_pc_o stable until new_pc_ready_i=1 in the same cycle.
    - Then returns to IDLE the next cycle.
- Latency: hit in cycle N → exception_en_o and flush_o in N+1. Earliest new_pc_valid_o is N+1+FLUSH_CYCLES.
- MEM inputs are ignored in FLUSH/REDIRECT; no queuing and no second event.
- new_pc_ready_i is ignored outside REDIRECT.
- Reset, including mid-sequence: state IDLE; all outputs 0 (excepttype_o, pc_next_o and new_pc_o are zero); counter 0.

Test Plan:
- Syscall at pc=0x0000_1000, slot=0, Status=0x1000_0001 → N+1: exception_en=1, is_exception=1, excepttype=0x08, pc_next=0x1000, flush for 2 cycles; new_pc=0x20 valid at N+3, drops the cycle after ready.
- Delay-slot ov at pc=0x0000_2004 → excepttype=0x0c, pc_next=0x2000, is_slot=1.
- Interrupt with Status=0x0000_0401 and Cause IP2 (0x0000_0400), plus a simultaneous ri flag → is_interrupt=1, is_exception=0, excepttype=0x00. The same stimulus with Status EXL=1 (0x0000_0403) → interrupt not taken, ri taken (0x0a).
- ERET with cp0_epc=0x100 while WB MTC0 writes EPC=0x200 → new_pc=0x200, excepttype=0x0e.
- Hold new_pc_ready=0 for 5 cycles in REDIRECT → valid and new_pc stable; a syscall arriving meanwhile is ignored; ready=1 → IDLE next cycle.
- Assert rst in the second FLUSH cycle → next cycle all outputs 0 and state IDLE; a fresh brk → excepttype 0x09 with normal timing.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Redirect handshake from the exception controller to fetch.
interface exc_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] new_pc_o;
  logic              new_pc_valid_o;
  logic              new_pc_ready_i;

  modport master (
    output new_pc_o,
    output new_pc_valid_o,
    input  new_pc_ready_i
  );

  modport slave (
    input  new_pc_o,
    input  new_pc_valid_o,
    output new_pc_ready_i
  );
endinterface

// File: rtl/exc_ctrl.sv
// MEM/WB exception and interrupt controller: trap decision,
// CP0 commit, pipeline flush and fetch redirect.
module exc_ctrl #(
  parameter int          ADDR_W       = 32,
  parameter int          EXC_TYPE_W   = 32,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid_i,
  input  logic [5:0]            mem_flags_i,
  input  logic [ADDR_W-1:0]     mem_pc_i,
  input  logic                  mem_is_slot_i,
  input  logic [31:0]           cp0_status_i,
  input  logic [31:0]           cp0_cause_i,
  input  logic [31:0]           cp0_epc_i,
  input  logic                  wb_cp0_we_i,
  input  logic [4:0]            wb_cp0_waddr_i,
  input  logic [31:0]           wb_cp0_data_i,
  output logic                  exception_en_o,
  output logic                  is_exception_o,
  output logic                  is_interrupt_o,
  output logic [EXC_TYPE_W-1:0] excepttype_o,
  output logic [ADDR_W-1:0]     pc_next_o,
  output logic                  is_slot_o,
  output logic                  flush_o,
  exc_ctrl_if.master            redir
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [4:0] EC_INT  = 5'h00;
  localparam logic [4:0] EC_SYS  = 5'h08;
  localparam logic [4:0] EC_BRK  = 5'h09;
  localparam logic [4:0] EC_RI   = 5'h0a;
  localparam logic [4:0] EC_OV   = 5'h0c;
  localparam logic [4:0] EC_TRAP = 5'h0d;
  localparam logic [4:0] EC_ERET = 5'h0e;

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]        cnt_q;
  logic [4:0]        code_q;
  logic              int_q;
  logic              slot_q;
  logic [ADDR_W-1:0] pc_next_q;
  logic [ADDR_W-1:0] tgt_q;

  logic [31:0]       fwd_status;
  logic [31:0]       fwd_cause;
  logic [31:0]       fwd_epc;
  logic              int_cond;
  logic              hit;
  logic              is_int_d;
  logic [4:0]        code_d;
  logic [ADDR_W-1:0] pc_next_d;
  logic [ADDR_W-1:0] tgt_d;
  logic              unused_ok;

  // Only the software interrupt bits of Cause are writable by MTC0.
  always_comb begin
    fwd_status = cp0_status_i;
    fwd_cause  = cp0_cause_i;
    fwd_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == REG_STATUS)
        fwd_status = wb_cp0_data_i;
      if (wb_cp0_waddr_i == REG_CAUSE)
        fwd_cause[9:8] = wb_cp0_data_i[9:8];
      if (wb_cp0_waddr_i == REG_EPC)
        fwd_epc = wb_cp0_data_i;
    end
  end

  assign int_cond = mem_valid_i
                  & fwd_status[0]
                  & ~fwd_status[1]
                  & (|(fwd_cause[15:8] & fwd_status[15:8]));

  assign unused_ok = ^{fwd_status[31:16], fwd_status[7:2],
                       fwd_cause[31:16], fwd_cause[7:0]};

  always_comb begin
    hit      = 1'b0;
    is_int_d = 1'b0;
    code_d   = EC_INT;
    if (int_cond) begin
      hit      = 1'b1;
      is_int_d = 1'b1;
    end else if (mem_valid_i) begin
      hit = 1'b1;
      if (mem_flags_i[0])      code_d = EC_RI;
      else if (mem_flags_i[1]) code_d = EC_OV;
      else if (mem_flags_i[2]) code_d = EC_TRAP;
      else if (mem_flags_i[3]) code_d = EC_SYS;
      else if (mem_flags_i[4]) code_d = EC_BRK;
      else if (mem_flags_i[5]) code_d = EC_ERET;
      else                     hit    = 1'b0;
    end
  end

  assign pc_next_d = mem_is_slot_i ? mem_pc_i - ADDR_W'(4)
                                   : mem_pc_i;
  assign tgt_d = (!is_int_d && code_d == EC_ERET)
               ? ADDR_W'(fwd_epc)
               : ADDR_W'(EXC_VECTOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      int_q     <= 1'b0;
      slot_q    <= 1'b0;
      pc_next_q <= '0;
      tgt_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            cnt_q     <= FC;
            code_q    <= code_d;
            int_q     <= is_int_d;
            slot_q    <= mem_is_slot_i;
            pc_next_q <= pc_next_d;
            tgt_q     <= tgt_d;
          end
        end
        FLUSH:    cnt_q <= cnt_q - 4'd1;
        REDIRECT: ;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (hit) state_d = FLUSH;
      FLUSH:    if (cnt_q == 4'd1) state_d = REDIRECT;
      REDIRECT: if (redir.new_pc_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    exception_en_o       = 1'b0;
    is_exception_o       = 1'b0;
    is_interrupt_o       = 1'b0;
    excepttype_o         = '0;
    pc_next_o            = '0;
    is_slot_o            = 1'b0;
    flush_o              = 1'b0;
    redir.new_pc_o       = '0;
    redir.new_pc_valid_o = 1'b0;
    if (state_q != IDLE) begin
      is_exception_o = ~int_q;
      is_interrupt_o = int_q;
      excepttype_o   = EXC_TYPE_W'(code_q);
      pc_next_o      = pc_next_q;
      is_slot_o      = slot_q;
      redir.new_pc_o = tgt_q;
    end
    if (state_q == FLUSH) begin
      flush_o        = 1'b1;
      exception_en_o = (cnt_q == FC);
    end
    if (state_q == REDIRECT)
      redir.new_pc_valid_o = 1'b1;
  end

endmodule
